// File: rtl/vga_scanout.sv
// vga_scanout
//   Generates 640x480@60 VGA timing from a 100 MHz clock using a divide-by-PIX_DIV
//   pixel tick. It reads a downscaled framebuffer (one texel covers 2^S x 2^S pixels)
//   and drives the VGA colour and sync pins. A one-clock frame_start pulse lets the
//   renderer swap or restart at each frame.
//
//   Pipeline on pixel ticks:
//     stage 0 : hcount/vcount, active, fb_rd_en, fb_addr for the pixel just loaded
//     stage 1 : sync and colour for the stage-0 pixel, one tick later
//   The framebuffer read completes between the two ticks, so colour and sync leave
//   exactly one pixel behind hcount/vcount, with no skew between them.
//
// Ports
//   clk_100mhz  in   system clock
//   rst_n       in   asynchronous active-low reset
//   fb_addr     out  framebuffer read address (holds while blanked)
//   fb_rd_en    out  high while fb_addr is valid (active region)
//   fb_data     in   {r,g,b} 4:4:4 texel, valid RD_LATENCY clocks after fb_addr
//   hcount      out  current pixel column, 0..H_TOTAL-1
//   vcount      out  current line, 0..V_TOTAL-1
//   active      out  (hcount,vcount) lies in the active region
//   frame_start out  one-clock pulse when the counters wrap to (0,0)
//   vga_r/g/b   out  colour, zero while blanked
//   vga_hs/vs   out  horizontal / vertical sync, active level SYNC_POL
module vga_scanout #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   PIX_DIV     = 4,
  parameter int   SCALE_SHIFT = 1,
  parameter int   FB_ADDR_W   = 17,
  parameter int   RD_LATENCY  = 2
) (
  input  logic                 clk_100mhz,
  input  logic                 rst_n,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_rd_en,
  input  logic [11:0]          fb_data,
  output logic [9:0]           hcount,
  output logic [9:0]           vcount,
  output logic                 active,
  output logic                 frame_start,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Low line bits that select a line inside one texel row.
  localparam logic [9:0] V_SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [FB_ADDR_W-1:0] FB_W     = FB_ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(PIX_DIV - 1);

  // The read must complete before the next tick samples fb_data.
  generate
    if (RD_LATENCY > PIX_DIV - 1) begin : g_rd_latency_check
      $error("vga_scanout: RD_LATENCY must not exceed PIX_DIV-1");
    end
  endgenerate

  logic [DIV_W-1:0]     div_r;
  logic [FB_ADDR_W-1:0] row_base_r;

  logic                 tick_s;
  logic                 h_wrap_s;
  logic                 frame_wrap_s;
  logic [9:0]           h_next_s;
  logic [9:0]           v_next_s;
  logic [FB_ADDR_W-1:0] row_base_next_s;
  logic [FB_ADDR_W-1:0] addr_next_s;
  logic                 active_next_s;
  logic                 hs_on_s;
  logic                 vs_on_s;

  // Next raster position and the stage-0 values that go with it.
  always_comb begin
    tick_s       = (div_r == DIV_LAST);
    h_wrap_s     = (hcount == H_LAST);
    frame_wrap_s = h_wrap_s && (vcount == V_LAST);

    if (h_wrap_s) begin
      h_next_s = 10'd0;
    end else begin
      h_next_s = hcount + 10'd1;
    end

    if (!h_wrap_s) begin
      v_next_s = vcount;
    end else if (vcount == V_LAST) begin
      v_next_s = 10'd0;
    end else begin
      v_next_s = vcount + 10'd1;
    end

    // Row base steps by one framebuffer row whenever a new texel row starts,
    // which avoids a v*FB_W multiplier.
    if (frame_wrap_s) begin
      row_base_next_s = '0;
    end else if (h_wrap_s && ((v_next_s & V_SUB_MASK) == 10'd0)) begin
      row_base_next_s = row_base_r + FB_W;
    end else begin
      row_base_next_s = row_base_r;
    end

    active_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
    addr_next_s   = row_base_next_s + FB_ADDR_W'(h_next_s >> SCALE_SHIFT);

    // Sync windows are decoded from the stage-0 position being retired.
    hs_on_s = (hcount >= HS_START) && (hcount < HS_END);
    vs_on_s = (vcount >= VS_START) && (vcount < VS_END);
  end

  // Pixel-tick divider.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Stage 0: raster counters, active flag and framebuffer address.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      hcount     <= 10'd0;
      vcount     <= 10'd0;
      row_base_r <= '0;
      active     <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
    end else if (tick_s) begin
      hcount     <= h_next_s;
      vcount     <= v_next_s;
      row_base_r <= row_base_next_s;
      active     <= active_next_s;
      fb_rd_en   <= active_next_s;
      if (active_next_s) begin
        fb_addr <= addr_next_s;
      end
    end
  end

  // Frame-start pulse, high only in the clock where (h,v) has just become (0,0).
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick_s && frame_wrap_s;
    end
  end

  // Stage 1: sync and colour; blanked pixels never look at fb_data.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r  <= 4'd0;
      vga_g  <= 4'd0;
      vga_b  <= 4'd0;
    end else if (tick_s) begin
      vga_hs <= hs_on_s ? SYNC_POL : ~SYNC_POL;
      vga_vs <= vs_on_s ? SYNC_POL : ~SYNC_POL;
      if (active) begin
        vga_r <= fb_data[11:8];
        vga_g <= fb_data[7:4];
        vga_b <= fb_data[3:0];
      end else begin
        vga_r <= 4'd0;
        vga_g <= 4'd0;
        vga_b <= 4'd0;
      end
    end
  end

endmodule
